// File: rtl/raw_stream_framer_if.sv
// Packetised raw pixel stream (data/valid/sop/eop) between the framer and the demosaic stage.
// The master drives the stream; the slave consumes it.
interface raw_stream_framer_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] raw_data;
   logic                  raw_valid;
   logic                  raw_sop;
   logic                  raw_eop;

   modport master (output raw_data, output raw_valid, output raw_sop, output raw_eop);
   modport slave  (input  raw_data, input  raw_valid, input  raw_sop, input  raw_eop);
endinterface

// File: rtl/raw_stream_framer.sv
// Converts sensor fv/lv timing into sop/eop-framed raw lines of exactly LINE_WIDTH x NUM_LINES,
// repairing or dropping malformed timing. Define RAW_FRAMER_TPG_EN to add the tpg_en test-pattern input.
module raw_stream_framer #(
   parameter int DATA_WIDTH = 8,
   parameter int LINE_WIDTH = 1280,
   parameter int NUM_LINES  = 720,
   parameter int CNT_W      = 12
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cam_fv,
   input  logic                  cam_lv,
   input  logic [DATA_WIDTH-1:0] cam_data,
`ifdef RAW_FRAMER_TPG_EN
   input  logic                  tpg_en,
`endif
   raw_stream_framer_if.master   raw,
   output logic                  frame_sop,
   output logic [CNT_W-1:0]      line_idx,
   output logic                  err_len,
   output logic                  err_lines
);

   typedef enum logic [2:0] {SYNC, IDLE, WAIT_LINE, IN_LINE, DROP} state_t;

   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] LINE_MAX  = CNT_W'(LINE_WIDTH);
   localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(LINE_WIDTH - 1);
   localparam logic [CNT_W-1:0] LINES_MAX = CNT_W'(NUM_LINES);
   localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(NUM_LINES - 1);

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      pix_cnt, pix_cnt_nxt;
   logic [CNT_W-1:0]      line_cnt, line_cnt_nxt;
   logic [CNT_W-1:0]      line_inc;
   logic [CNT_W-1:0]      accept_idx;
   logic                  accept;
   logic                  frame_start;
   logic                  set_len;
   logic                  set_lines;
   logic [DATA_WIDTH-1:0] pix_value;

   logic                  hold_valid;
   logic [DATA_WIDTH-1:0] hold_data;
   logic                  hold_sop;
   logic                  hold_last;
   logic                  hold_top;

   // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= SYNC;
         pix_cnt  <= '0;
         line_cnt <= '0;
      end else begin
         state    <= state_nxt;
         pix_cnt  <= pix_cnt_nxt;
         line_cnt <= line_cnt_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt    = state;
      pix_cnt_nxt  = pix_cnt;
      line_cnt_nxt = line_cnt;
      line_inc     = line_cnt + ONE;
      accept       = 1'b0;
      accept_idx   = pix_cnt;
      frame_start  = 1'b0;
      set_len      = 1'b0;
      set_lines    = 1'b0;
      unique case (state)
         SYNC: begin
            if (!cam_fv) state_nxt = IDLE;
         end
         IDLE: begin
            if (cam_fv) begin
               state_nxt    = WAIT_LINE;
               frame_start  = 1'b1;
               line_cnt_nxt = '0;
            end
         end
         WAIT_LINE: begin
            // Frame end has priority: lv while fv is low is not a pixel.
            if (!cam_fv) begin
               state_nxt = IDLE;
               set_lines = 1'b1;
            end else if (cam_lv) begin
               state_nxt   = IN_LINE;
               accept      = 1'b1;
               accept_idx  = '0;
               pix_cnt_nxt = ONE;
            end
         end
         IN_LINE: begin
            if (cam_fv && cam_lv) begin
               if (pix_cnt < LINE_MAX) begin
                  accept      = 1'b1;
                  pix_cnt_nxt = pix_cnt + ONE;
               end else begin
                  set_len = 1'b1;
               end
            end else begin
               // Line closes first; a simultaneous fv fall then closes the frame.
               line_cnt_nxt = line_inc;
               if (pix_cnt < LINE_MAX) set_len = 1'b1;
               if (!cam_fv) begin
                  state_nxt = IDLE;
                  set_lines = (line_inc < LINES_MAX);
               end else if (line_inc == LINES_MAX) begin
                  state_nxt = DROP;
               end else begin
                  state_nxt = WAIT_LINE;
               end
            end
         end
         DROP: begin
            if (!cam_fv) state_nxt = IDLE;
            else if (cam_lv) set_lines = 1'b1;
         end
         default: state_nxt = SYNC;
      endcase
   end

`ifdef RAW_FRAMER_TPG_EN
   logic             tpg_active;
   logic [CNT_W-1:0] tpg_sum;

   // Latched only while idle so a frame never switches source part-way.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)            tpg_active <= 1'b0;
      else if (state == IDLE)  tpg_active <= tpg_en;
   end

   always_comb begin
      tpg_sum   = accept_idx + line_cnt;
      pix_value = cam_data;
      if (tpg_active) begin
         pix_value    = DATA_WIDTH'(tpg_sum);
         pix_value[0] = accept_idx[0];
      end
   end
`else
   assign pix_value = cam_data;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
         hold_sop   <= 1'b0;
         hold_last  <= 1'b0;
         hold_top   <= 1'b0;
      end else begin
         hold_valid <= accept;
         if (accept) begin
            hold_data <= pix_value;
            hold_sop  <= (accept_idx == '0);
            hold_last <= (accept_idx == LAST_PIX);
            hold_top  <= (line_cnt == '0);
         end
      end
   end

   // A held pixel is the line's last when it sits at LINE_WIDTH-1 or no further pixel arrives behind it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         raw.raw_data  <= '0;
         raw.raw_valid <= 1'b0;
         raw.raw_sop   <= 1'b0;
         raw.raw_eop   <= 1'b0;
         frame_sop     <= 1'b0;
      end else begin
         raw.raw_valid <= hold_valid;
         raw.raw_sop   <= hold_valid & hold_sop;
         raw.raw_eop   <= hold_valid & (hold_last | ~accept);
         frame_sop     <= hold_valid & hold_sop & hold_top;
         if (hold_valid) raw.raw_data <= hold_data;
      end
   end

   // Frame start wins over a trailing eop of the previous frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         line_idx <= '0;
      end else if (frame_start) begin
         line_idx <= '0;
      end else if (raw.raw_valid && raw.raw_eop) begin
         line_idx <= (line_idx == LAST_LINE) ? '0 : line_idx + ONE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_len   <= 1'b0;
         err_lines <= 1'b0;
      end else begin
         if (frame_start)  err_len   <= 1'b0;
         else if (set_len) err_len   <= 1'b1;
         if (set_lines)    err_lines <= 1'b1;
      end
   end

endmodule

// File: tb/tb_raw_stream_framer.sv
// Self-checking bench for raw_stream_framer: frame-level reference model (expected pixel queue with
// arrival cycle), directed scenarios with literal expectations, then randomized frames.
module tb_raw_stream_framer;
   localparam int DW = 8;
   localparam int LW = 4;
   localparam int NL = 3;
   localparam int CW = 12;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          cam_fv = 1'b0;
   logic          cam_lv = 1'b0;
   logic [DW-1:0] cam_data = '0;
`ifdef RAW_FRAMER_TPG_EN
   logic          tpg_en = 1'b0;
`endif
   logic          frame_sop;
   logic [CW-1:0] line_idx;
   logic          err_len;
   logic          err_lines;

   raw_stream_framer_if #(.DATA_WIDTH(DW)) raw ();

   raw_stream_framer #(
      .DATA_WIDTH(DW), .LINE_WIDTH(LW), .NUM_LINES(NL), .CNT_W(CW)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .cam_fv   (cam_fv),
      .cam_lv   (cam_lv),
      .cam_data (cam_data),
`ifdef RAW_FRAMER_TPG_EN
      .tpg_en   (tpg_en),
`endif
      .raw      (raw),
      .frame_sop(frame_sop),
      .line_idx (line_idx),
      .err_len  (err_len),
      .err_lines(err_lines)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            stamp;
      logic [DW-1:0] data;
      logic          sop;
      logic          eop;
      logic          fsop;
      int            line;
   } exp_t;

   exp_t          exp_q[$];
   int            checks = 0;
   int            errors = 0;
   bit            exp_err_lines = 0;

   int            n_valid, n_sop, n_eop, n_fsop;
   int            first_valid_cyc, first_pix_cyc, obs_col;
   logic [DW-1:0] obs [NL][8];

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [DW-1:0] tpg_val(input int x, input int y);
      logic [DW-1:0] v;
      v    = DW'(x + y);
      v[0] = x[0];
      return v;
   endfunction

   task automatic clear_obs();
      n_valid = 0; n_sop = 0; n_eop = 0; n_fsop = 0;
      first_valid_cyc = -1; first_pix_cyc = -1; obs_col = 0;
      for (int l = 0; l < NL; l++)
         for (int c = 0; c < 8; c++) obs[l][c] = '0;
   endtask

   task automatic drive(input logic fv, input logic lv, input logic [DW-1:0] d);
      @(posedge clk);
      #1;
      cam_fv = fv; cam_lv = lv; cam_data = d;
   endtask

   // Pulse reset; when keep_inputs is set the sensor keeps its current (mid-frame) timing.
   task automatic do_reset(input bit keep_inputs);
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      if (!keep_inputs) begin cam_fv = 1'b0; cam_lv = 1'b0; end
      exp_q.delete();
      exp_err_lines = 0;
      #1;
      check("rst_valid", raw.raw_valid, 0);
      check("rst_sop", raw.raw_sop, 0);
      check("rst_eop", raw.raw_eop, 0);
      check("rst_data", raw.raw_data, 0);
      check("rst_fsop", frame_sop, 0);
      check("rst_line_idx", line_idx, 0);
      check("rst_err_len", err_len, 0);
      check("rst_err_lines", err_lines, 0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   // Drives one frame and records the pixels the framer must emit, each due two cycles after it is driven.
   task automatic send_frame(input int nlines, input int lens[8], input bit rnd, input logic [DW-1:0] base,
                             input bit tpg, input bit join_end);
      logic [DW-1:0] d;
      logic [DW-1:0] run;
      int            porch, gap, kept;
      bit            bad;
      exp_t          e;
      run   = base;
      bad   = 0;
      porch = $urandom_range(1, 2);
      for (int p = 0; p < porch; p++) drive(1'b1, 1'b0, '0);
      @(posedge clk);
      #1;
      check("err_len_clear_at_fv_rise", err_len, 0);
      for (int li = 0; li < nlines; li++) begin
         kept = (lens[li] < LW) ? lens[li] : LW;
         if (li < NL && lens[li] != LW) bad = 1;
         for (int k = 0; k < lens[li]; k++) begin
            d = rnd ? DW'($urandom) : run;
            run = run + 1'b1;
            drive(1'b1, 1'b1, d);
            if (first_pix_cyc < 0) first_pix_cyc = cyc;
            if (li < NL && k < LW) begin
               e.stamp = cyc + 2;
               e.data  = tpg ? tpg_val(k, li) : d;
               e.sop   = (k == 0);
               e.eop   = (k == kept - 1);
               e.fsop  = (k == 0) && (li == 0);
               e.line  = li;
               exp_q.push_back(e);
            end
         end
         if (li == nlines - 1 && join_end) begin
            drive(1'b0, 1'b0, '0);
         end else begin
            gap = $urandom_range(1, 2);
            for (int g = 0; g < gap; g++) drive(1'b1, 1'b0, '0);
         end
      end
      if (!join_end) drive(1'b0, 1'b0, '0);
      if (nlines != NL) exp_err_lines = 1;
      repeat (3) drive(1'b0, 1'b0, '0);
      check("err_len_frame", err_len, bad);
      check("err_lines_frame", err_lines, exp_err_lines);
   endtask

   initial begin : main
      exp_t e;
      int   lens[8];
      int   r, nl;
      clear_obs();

      // Per-cycle comparison of the DUT stream against the expected queue.
      fork
         forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
               check("pixel_time", cyc, exp_q[0].stamp);
               void'(exp_q.pop_front());
            end
            if (raw.raw_valid) begin
               n_valid++;
               if (raw.raw_sop) begin n_sop++; obs_col = 0; end
               if (raw.raw_eop) n_eop++;
               if (frame_sop) n_fsop++;
               if (first_valid_cyc < 0) first_valid_cyc = cyc;
               if (line_idx < NL && obs_col < 8) obs[line_idx][obs_col] = raw.raw_data;
               obs_col++;
               if (exp_q.size() == 0) begin
                  check("unexpected_valid", raw.raw_valid, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("pixel_time", cyc, e.stamp);
                  check("raw_data", raw.raw_data, e.data);
                  check("raw_sop", raw.raw_sop, e.sop);
                  check("raw_eop", raw.raw_eop, e.eop);
                  check("frame_sop", frame_sop, e.fsop);
                  check("line_idx", line_idx, e.line);
               end
            end
         end
      join_none

      // Power-on reset and idle
      do_reset(1'b0);
      repeat (3) drive(1'b0, 1'b0, '0);

      // Clean frame: 3 lines of 4 pixels 0x10..0x1B
      clear_obs();
      send_frame(3, '{4, 4, 4, 0, 0, 0, 0, 0}, 0, 8'h10, 0, 0);
      check("clean_valids", n_valid, 12);
      check("clean_sops", n_sop, 3);
      check("clean_eops", n_eop, 3);
      check("clean_frame_sops", n_fsop, 1);
      check("clean_latency", first_valid_cyc - first_pix_cyc, 2);
      check("clean_first_px", obs[0][0], 8'h10);
      check("clean_line1_sop_px", obs[1][0], 8'h14);
      check("clean_last_px", obs[2][3], 8'h1B);
      check("clean_err_len", err_len, 0);

      // Short line 1 (0x14..0x16), then a clean frame clears err_len at fv rise
      clear_obs();
      send_frame(3, '{4, 3, 4, 0, 0, 0, 0, 0}, 0, 8'h10, 0, 0);
      check("short_valids", n_valid, 11);
      check("short_eop_px", obs[1][2], 8'h16);
      check("short_err_len", err_len, 1);
      send_frame(3, '{4, 4, 4, 0, 0, 0, 0, 0}, 0, 8'h20, 0, 1);
      check("after_short_err_len", err_len, 0);

      // Long line of 6 pixels: only first 4 emitted
      clear_obs();
      send_frame(3, '{4, 6, 4, 0, 0, 0, 0, 0}, 0, 8'h30, 0, 0);
      check("long_valids", n_valid, 12);
      check("long_eops", n_eop, 3);
      check("long_eop_px", obs[1][3], 8'h37);
      check("long_err_len", err_len, 1);

      // Four lines: fourth dropped
      clear_obs();
      send_frame(4, '{4, 4, 4, 4, 0, 0, 0, 0}, 0, 8'h40, 0, 0);
      check("extra_valids", n_valid, 12);
      check("extra_err_lines", err_lines, 1);

      // Two-line frame after reset
      do_reset(1'b0);
      repeat (2) drive(1'b0, 1'b0, '0);
      clear_obs();
      send_frame(2, '{4, 4, 0, 0, 0, 0, 0, 0}, 0, 8'h50, 0, 1);
      check("few_valids", n_valid, 8);
      check("few_err_lines", err_lines, 1);

      // Reset mid-line with fv high: nothing until fv has gone low and high again
      do_reset(1'b0);
      repeat (2) drive(1'b0, 1'b0, '0);
      drive(1'b1, 1'b0, '0);
      drive(1'b1, 1'b0, '0);
      drive(1'b1, 1'b1, 8'h60);
      drive(1'b1, 1'b1, 8'h61);
      do_reset(1'b1);
      clear_obs();
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, DW'(8'h70 + i));
      drive(1'b1, 1'b0, '0);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, DW'(8'h78 + i));
      drive(1'b1, 1'b0, '0);
      repeat (3) drive(1'b0, 1'b0, '0);
      check("sync_no_output", n_valid, 0);
      check("sync_err_lines", err_lines, 0);
      check("sync_err_len", err_len, 0);
      send_frame(3, '{4, 4, 4, 0, 0, 0, 0, 0}, 0, 8'h80, 0, 0);
      check("post_sync_valids", n_valid, 12);
      check("post_sync_frame_sops", n_fsop, 1);

`ifdef RAW_FRAMER_TPG_EN
      // Test pattern: (x + y) with LSB forced to column parity
      clear_obs();
      tpg_en = 1'b1;
      drive(1'b0, 1'b0, '0);
      send_frame(3, '{4, 4, 4, 0, 0, 0, 0, 0}, 1, 8'h00, 1, 0);
      tpg_en = 1'b0;
      check("tpg_x2_y1", obs[1][2], 8'h02);
      check("tpg_x3_y2", obs[2][3], 8'h05);
      check("tpg_valids", n_valid, 12);
      check("tpg_sops", n_sop, 3);
      check("tpg_latency", first_valid_cyc - first_pix_cyc, 2);
      drive(1'b0, 1'b0, '0);
      send_frame(3, '{4, 4, 4, 0, 0, 0, 0, 0}, 0, 8'h90, 0, 0);
`endif

      // Randomized frames
      for (int f = 0; f < 30; f++) begin
         r  = $urandom_range(0, 5);
         nl = (r == 0) ? 2 : (r == 1) ? 4 : 3;
         for (int l = 0; l < 8; l++) begin
            r = $urandom_range(0, 7);
            lens[l] = (r == 0) ? 2 : (r == 1) ? 3 : (r == 2) ? 5 : (r == 3) ? 6 : 4;
         end
         send_frame(nl, lens, 1, '0, 0, bit'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, '0);
      end

      repeat (5) drive(1'b0, 1'b0, '0);
      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "time limit");
   end
endmodule
